// File: rtl/apb_completer_regfile.sv
// APB completer with a bank of read/write registers, programmable wait states,
// out-of-range error response and a combinational debug read port.
module apb_completer_regfile #(
    parameter int addrwidth   = 16,
    parameter int datawidth   = 16,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic                        psel,
    input  logic                        penable,
    input  logic [addrwidth-1:0]        paddr,
    input  logic                        pwrite,
    input  logic [datawidth-1:0]        pwdata,
    output logic                        pready,
    output logic                        pslverr,
    output logic [datawidth-1:0]        prdata,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_idx,
    output logic [datawidth-1:0]        dbg_data
);

    localparam int                   IDXW      = $clog2(NUM_REGS);
    localparam logic [addrwidth:0]   ADDR_LIM  = (addrwidth+1)'(NUM_REGS);
    localparam logic [IDXW:0]        DBG_LIM   = (IDXW+1)'(NUM_REGS);
    localparam logic [4:0]           WAIT_C    = 5'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, COUNT, RESP} state_t;

    state_t                 state, state_nxt;
    logic [4:0]             cnt;
    logic [datawidth-1:0]   regs [NUM_REGS];

    logic                   access;
    logic                   at_wait;
    logic                   addr_ok;
    logic [IDXW-1:0]        idx;
    logic                   commit;
    logic                   cnt_clr;
    logic                   cnt_inc;

    assign access  = psel & penable;
    assign at_wait = (cnt == WAIT_C);
    assign addr_ok = ({1'b0, paddr} < ADDR_LIM);
    assign idx     = paddr[IDXW-1:0];

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 5'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (access) state_nxt = COUNT;
            COUNT: begin
                if (!access)
                    state_nxt = IDLE;
                else if (at_wait)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        commit  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            IDLE:  cnt_clr = 1'b1;
            COUNT: begin
                commit  = access & at_wait;
                cnt_inc = access & ~at_wait;
            end
            default: ;
        endcase
    end

    // Response and register bank: a protocol abort never reaches commit, so nothing changes.
    always_ff @(posedge pclk) begin
        if (preset) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            pready  <= commit;
            pslverr <= commit & ~addr_ok;
            if (commit && !pwrite)
                prdata <= addr_ok ? regs[idx] : '0;
            if (commit && pwrite && addr_ok)
                regs[idx] <= pwdata;
        end
    end

    always_comb begin
        dbg_data = '0;
        if ({1'b0, dbg_idx} < DBG_LIM)
            dbg_data = regs[dbg_idx];
    end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench for apb_completer_regfile: one instance with one wait state,
// one with none, sharing clock, reset and the APB request signals.
module tb_apb_completer_regfile;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [15:0] paddr, pwdata;
    logic [3:0]  dbg_idx;

    logic        pready1, pslverr1, pready0, pslverr0;
    logic [15:0] prdata1, dbg_data1, prdata0, dbg_data0;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_completer_regfile #(.addrwidth(16), .datawidth(16), .NUM_REGS(16), .WAIT_CYCLES(1)) u1 (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready1), .pslverr(pslverr1),
        .prdata(prdata1), .dbg_idx(dbg_idx), .dbg_data(dbg_data1)
    );

    apb_completer_regfile #(.addrwidth(16), .datawidth(16), .NUM_REGS(16), .WAIT_CYCLES(0)) u0 (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready0), .pslverr(pslverr0),
        .prdata(prdata0), .dbg_idx(dbg_idx), .dbg_data(dbg_data0)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        err;
        logic [15:0] rdata;
    } vec_t;

    vec_t        vecs [9];
    logic [15:0] exp_regs [16];

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full transfer on the one-wait-state instance; lat counts edges from penable=1 to pready.
    task automatic xfer1(input logic wr, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic err, output logic [15:0] rd);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (pready1 === 1'b1) begin
                lat = n;
                break;
            end
        end
        err = pslverr1;
        rd  = prdata1;
        psel = 1'b0; penable = 1'b0;
        tick();
        check("pready_one_cycle", {31'd0, pready1}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic        err;
        logic [15:0] rd;

        vecs[0] = '{1'b1, 16'd3,  16'hA5A5, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 16'd3,  16'h0000, 1'b0, 16'hA5A5};
        vecs[2] = '{1'b1, 16'd16, 16'h1234, 1'b1, 16'hA5A5};
        vecs[3] = '{1'b0, 16'd20, 16'h0000, 1'b1, 16'h0000};
        vecs[4] = '{1'b1, 16'd15, 16'h00FF, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 16'd15, 16'h0000, 1'b0, 16'h00FF};
        vecs[6] = '{1'b1, 16'd7,  16'h8001, 1'b0, 16'h00FF};
        vecs[7] = '{1'b0, 16'd7,  16'h0000, 1'b0, 16'h8001};
        vecs[8] = '{1'b0, 16'd0,  16'h0000, 1'b0, 16'h0000};
        for (int i = 0; i < 16; i++) exp_regs[i] = 16'h0000;

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; dbg_idx = '0;
        tick(); tick();
        preset = 1'b0;
        tick();
        check("reset_pready",  {31'd0, pready1},  32'd0);
        check("reset_pslverr", {31'd0, pslverr1}, 32'd0);
        check("reset_prdata",  {16'd0, prdata1},  32'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_idx = 4'(i);
            #1;
            check("reset_reg", {16'd0, dbg_data1}, 32'd0);
        end

        for (int v = 0; v < 9; v++) begin
            xfer1(vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, err, rd);
            check("latency", lat, 32'd3);
            check("pslverr", {31'd0, err}, {31'd0, vecs[v].err});
            check("prdata",  {16'd0, rd},  {16'd0, vecs[v].rdata});
            tick(); tick();
            check("prdata_hold", {16'd0, prdata1}, {16'd0, vecs[v].rdata});
            if (vecs[v].wr && vecs[v].addr < 16) begin
                exp_regs[vecs[v].addr[3:0]] = vecs[v].wdata;
                dbg_idx = vecs[v].addr[3:0];
                #1;
                check("dbg_after_write", {16'd0, dbg_data1}, {16'd0, vecs[v].wdata});
            end
        end
        for (int i = 0; i < 16; i++) begin
            dbg_idx = 4'(i);
            #1;
            check("reg_sweep", {16'd0, dbg_data1}, {16'd0, exp_regs[i]});
        end

        // psel drops while counting: the write to reg 5 must be abandoned.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd5; pwdata = 16'hFFFF;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("abort_no_pready", {31'd0, pready1}, 32'd0);
        end
        dbg_idx = 4'd5;
        #1;
        check("abort_reg5", {16'd0, dbg_data1}, 32'd0);
        xfer1(1'b0, 16'd5, 16'h0000, lat, err, rd);
        check("abort_read_lat",  lat, 32'd3);
        check("abort_read_data", {16'd0, rd}, 32'd0);

        // Reset lands on what would otherwise be the commit edge of a write.
        xfer1(1'b0, 16'd3, 16'h0000, lat, err, rd);
        check("pre_reset_read", {16'd0, rd}, 32'h0000A5A5);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd2; pwdata = 16'hBEEF;
        tick();
        penable = 1'b1;
        tick(); tick();
        preset = 1'b1;
        tick();
        check("rst_pready", {31'd0, pready1}, 32'd0);
        check("rst_prdata", {16'd0, prdata1}, 32'd0);
        dbg_idx = 4'd2;
        #1;
        check("rst_reg2", {16'd0, dbg_data1}, 32'd0);
        dbg_idx = 4'd3;
        #1;
        check("rst_reg3", {16'd0, dbg_data1}, 32'd0);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        tick();
        check("rst_after_pready", {31'd0, pready1}, 32'd0);

        // No wait states, back-to-back writes with psel/penable held high.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd0; pwdata = 16'h0001;
        tick();
        penable = 1'b1;
        tick();
        check("b2b_first_count", {31'd0, pready0}, 32'd0);
        tick();
        check("b2b_pready_a", {31'd0, pready0}, 32'd1);
        check("b2b_pslverr_a", {31'd0, pslverr0}, 32'd0);
        paddr = 16'd1; pwdata = 16'h0002;
        tick();
        check("b2b_resp_end", {31'd0, pready0}, 32'd0);
        tick();
        check("b2b_second_count", {31'd0, pready0}, 32'd0);
        tick();
        check("b2b_pready_b", {31'd0, pready0}, 32'd1);
        check("b2b_pslverr_b", {31'd0, pslverr0}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        tick();
        check("b2b_pready_low", {31'd0, pready0}, 32'd0);
        dbg_idx = 4'd0;
        #1;
        check("b2b_reg0", {16'd0, dbg_data0}, 32'h00000001);
        dbg_idx = 4'd1;
        #1;
        check("b2b_reg1", {16'd0, dbg_data0}, 32'h00000002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
